// File: rtl/cpu_cmd_sequencer.sv
// Host command sequencer: decodes UART command words into CPU reset, step,
// run and PC-readback actions, then sends exactly one reply word.
//
// Ports:
//   div_clk, reset        clock and synchronous active-high reset
//   rx_data, rx_valid     received command/argument word and its strobe
//   tx_data, tx_start     reply word (held) and its one-cycle launch strobe
//   tx_done               transmitter completion strobe
//   pc                    CPU program counter, sampled into replies
//   cpu_reset, cpu_run    CPU reset request and clock enable
//   state, busy           FSM state encoding and not-idle flag
module cpu_cmd_sequencer #(
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  parameter int RESET_CYC = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter logic [DATA_W-1:0] ACK_CODE = DATA_W'(3),
  parameter logic [DATA_W-1:0] NAK_CODE = '1
) (
  input  logic              div_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  input  logic [DATA_W-1:0] pc,
  output logic              cpu_reset,
  output logic              cpu_run,
  output logic [2:0]        state,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET_CPU = 3'd1,
    S_WAIT_ARG  = 3'd2,
    S_STEPPING  = 3'd3,
    S_RUNNING   = 3'd4,
    S_SEND      = 3'd5,
    S_WAIT_TX   = 3'd6
  } state_t;

  localparam int TMAX =
    (TIMEOUT_CYC > RESET_CYC) ? TIMEOUT_CYC : RESET_CYC;
  localparam int TW = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] RST_LAST = TW'(RESET_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [DATA_W-1:0] CMD_RESET = DATA_W'(1);
  localparam logic [DATA_W-1:0] CMD_RDPC  = DATA_W'(2);
  localparam logic [DATA_W-1:0] CMD_STEP  = DATA_W'(3);
  localparam logic [DATA_W-1:0] CMD_RUN   = DATA_W'(4);
  localparam logic [DATA_W-1:0] CMD_HALT  = DATA_W'(5);

  state_t            st_q, st_d;
  logic [CNT_W-1:0]  step_q, step_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              halt_q, halt_d;
  logic [DATA_W-1:0] txd_q, txd_d;

  always_ff @(posedge div_clk) begin
    if (reset) begin
      st_q   <= S_IDLE;
      step_q <= '0;
      tmo_q  <= '0;
      halt_q <= 1'b0;
      txd_q  <= '0;
    end else begin
      st_q   <= st_d;
      step_q <= step_d;
      tmo_q  <= tmo_d;
      halt_q <= halt_d;
      txd_q  <= txd_d;
    end
  end

  // tmo_d defaults to zero, so the cycle timer restarts whenever
  // a state is left or entered.
  always_comb begin
    st_d   = st_q;
    step_d = step_q;
    tmo_d  = '0;
    halt_d = 1'b0;
    txd_d  = txd_q;
    case (st_q)
      S_IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            rx_data == CMD_RESET: st_d = S_RESET_CPU;
            rx_data == CMD_RDPC: begin
              txd_d = pc;
              st_d  = S_SEND;
            end
            rx_data == CMD_STEP: st_d = S_WAIT_ARG;
            rx_data == CMD_RUN:  st_d = S_RUNNING;
            default: begin
              txd_d = NAK_CODE;
              st_d  = S_SEND;
            end
          endcase
        end
      end
      S_RESET_CPU: begin
        if (tmo_q == RST_LAST) begin
          txd_d = ACK_CODE;
          st_d  = S_SEND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WAIT_ARG: begin
        if (rx_valid) begin
          step_d = rx_data[CNT_W-1:0];
          st_d   = S_STEPPING;
        end else if (tmo_q == TMO_LAST) begin
          txd_d = NAK_CODE;
          st_d  = S_SEND;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_STEPPING: begin
        if (step_q != '0) begin
          step_d = step_q - CNT_W'(1);
        end else begin
          txd_d = pc;
          st_d  = S_SEND;
        end
      end
      // HALT stops the CPU for one cycle while still in RUNNING,
      // so the sampled pc includes every executed instruction.
      S_RUNNING: begin
        if (halt_q) begin
          txd_d = pc;
          st_d  = S_SEND;
        end else begin
          halt_d = rx_valid && (rx_data == CMD_HALT);
        end
      end
      S_SEND: st_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_done) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_reset = (st_q == S_RESET_CPU);
    cpu_run   = ((st_q == S_STEPPING) && (step_q != '0))
             || ((st_q == S_RUNNING) && !halt_q);
    tx_start  = (st_q == S_SEND);
    busy      = (st_q != S_IDLE);
    state     = st_q;
    tx_data   = txd_q;
  end

endmodule

// File: doc/cpu_cmd_sequencer.md
CPU_CMD_SEQUENCER -- requirements
Module: cpu_cmd_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 32: command, argument, PC and reply word width.
- CNT_W, 16: step-count width; step arguments are truncated to the low CNT_W bits.
- RESET_CYC, 4: cpu_reset pulse length in div_clk cycles, minimum 1.
- TIMEOUT_CYC, 1000: wait limit for an argument word, minimum 1.
- ACK_CODE, 3: reply word for a successful command with no data.
- NAK_CODE, all ones: reply word for an unknown or timed-out command.
REQ-002 Ports, one per line: name  direction  width  meaning.
- div_clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- rx_data  in  DATA_W  word from the external UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle.
- tx_data  out  DATA_W  reply word, registered, held stable from tx_start until tx_done.
- tx_start  out  1  one-cycle strobe that launches the external UART transmitter.
- tx_done  in  1  one-cycle strobe from the transmitter when the word has been sent.
- pc  in  DATA_W  CPU program counter.
- cpu_reset  out  1  CPU reset request.
- cpu_run  out  1  CPU clock enable; the CPU advances one instruction per high cycle.
- state  out  3  current FSM state encoding.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-003 FSM states and encodings: IDLE=0, RESET_CPU=1, WAIT_ARG=2, STEPPING=3, RUNNING=4, SEND=5, WAIT_TX=6.
REQ-004 In IDLE, a word received with rx_valid is decoded as a command.
- 1 (RESET): go to RESET_CPU.
- 2 (READ_PC): latch pc into tx_data, then go to SEND.
- 3 (STEP): go to WAIT_ARG.
- 4 (RUN): go to RUNNING.
- Any other value, including 5 (HALT): tx_data=NAK_CODE, then go to SEND.
REQ-005 RESET_CPU: cpu_reset is high for exactly RESET_CYC consecutive cycles; then tx_data=ACK_CODE and go to SEND.
REQ-006 WAIT_ARG: on rx_valid, load the step counter with rx_data[CNT_W-1:0] and go to STEPPING.
REQ-007 WAIT_ARG timeout: after TIMEOUT_CYC cycles with no rx_valid, tx_data=NAK_CODE and go to SEND; the timeout counter clears on every entry to WAIT_ARG.
REQ-008 STEPPING: cpu_run is high for exactly N consecutive cycles, N being the loaded count; the counter decrements once per run cycle.
REQ-009 When the step count reaches zero, latch pc into tx_data in the cycle after the last run cycle, then go to SEND.
REQ-010 Step argument 0: cpu_run never goes high; pc is latched on the next cycle, then go to SEND.
REQ-011 RUNNING: cpu_run stays high continuously; tx_start is not pulsed on entry.
REQ-012 RUNNING exit: on rx_valid with rx_data==5, cpu_run drops in the next cycle, pc is latched into tx_data in that same cycle, then go to SEND.
REQ-013 RUNNING, any other received word: ignored, cpu_run stays high.
REQ-014 SEND: tx_start is high for exactly one cycle, then go to WAIT_TX.
REQ-015 WAIT_TX: on tx_done, go to IDLE; there is no timeout in WAIT_TX.
REQ-016 rx_valid arriving in RESET_CPU, STEPPING, SEND or WAIT_TX is discarded, including when it coincides with tx_done.
REQ-017 cpu_reset and cpu_run are never high in the same cycle.
REQ-018 Every command produces exactly one reply, with exactly one tx_start pulse per reply.
REQ-019 Back-to-back commands: a command word arriving in the first IDLE cycle after tx_done is accepted.

Reset
REQ-020 When reset is high at a clock edge, the following hold:
- state=IDLE, busy=0, cpu_reset=0, cpu_run=0.
- tx_start=0, tx_data=0.
- Step and timeout counters are 0.
REQ-021 Reset asserted mid-operation aborts the command immediately: no reply is sent and no further cpu_run cycles occur.

Verification
REQ-022 rx 1 -> cpu_reset high for 4 cycles, then one tx_start with tx_data=3, then IDLE after tx_done.
REQ-023 rx 3, then rx 5 -> cpu_run high for exactly 5 cycles, then tx_start with tx_data equal to pc sampled after the last run cycle.
REQ-024 rx 3, then rx 0 -> zero cpu_run cycles, then reply equal to pc; rx 3 with no argument for 1000 cycles -> reply NAK_CODE.
REQ-025 rx 4, then rx 7, then rx 5 -> cpu_run stays high through the 7, drops the cycle after the 5, and the reply equals pc.
REQ-026 rx 9 -> reply NAK_CODE; rx_valid coinciding with tx_done in WAIT_TX -> word dropped and no second reply.
REQ-027 reset asserted during STEPPING with 3 of 10 cycles done -> cpu_run=0 next cycle, state=IDLE, no tx_start.
